// File: rtl/ooo_pkg.sv
// ooo_pkg: shared definitions for the out-of-order issue path.
//   Constants : ENTRY_W, PREG_W, NUM_PREGS, entry field offsets (*_LSB).
//   Types     : entry_t, the renamed entry laid out MSB-first as
//               control | instr | pc | mapc | mapb | mapa.
//   Functions : src_ready, the allocate-time operand readiness with
//               same-edge wakeup bypass.
package ooo_pkg;

  localparam int ENTRY_W   = 170;
  localparam int PREG_W    = 6;
  localparam int NUM_PREGS = 64;

  localparam int MAPA_LSB  = 0;
  localparam int MAPB_LSB  = 6;
  localparam int MAPC_LSB  = 12;
  localparam int PC_LSB    = 18;
  localparam int INSTR_LSB = 50;
  localparam int CTRL_LSB  = 82;

  typedef struct packed {
    logic [ENTRY_W-CTRL_LSB-1:0]    control;
    logic [CTRL_LSB-INSTR_LSB-1:0]  instr;
    logic [INSTR_LSB-PC_LSB-1:0]    pc;
    logic [PC_LSB-MAPC_LSB-1:0]     mapc;
    logic [MAPC_LSB-MAPB_LSB-1:0]   mapb;
    logic [MAPB_LSB-MAPA_LSB-1:0]   mapa;
  } entry_t;

  // Register 0 is hard-wired ready; a wakeup on the allocate edge is bypassed.
  function automatic logic src_ready(input logic [PREG_W-1:0]    map,
                                     input logic [NUM_PREGS-1:0] busy,
                                     input logic                 wv,
                                     input logic [PREG_W-1:0]    wr);
    return (!busy[map]) | (map == {PREG_W{1'b0}}) | (wv & (wr == map));
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: rename-side allocate and execute-side issue handshake.
//   alloc_valid/alloc_entry/issue_halt : rename allocation with back-pressure
//   issue_valid/issue_entry/exe_ready  : registered issue port to execute
//   modport master : rename/execute side; modport slave : the scheduler.
interface issue_scheduler_if;
  import ooo_pkg::*;

  logic               alloc_valid;
  logic [ENTRY_W-1:0] alloc_entry;
  logic               issue_halt;
  logic               issue_valid;
  logic [ENTRY_W-1:0] issue_entry;
  logic               exe_ready;

  modport master (output alloc_valid, alloc_entry, exe_ready,
                  input  issue_halt, issue_valid, issue_entry);
  modport slave  (input  alloc_valid, alloc_entry, exe_ready,
                  output issue_halt, issue_valid, issue_entry);
endinterface

// File: rtl/issue_scheduler_age_select.sv
// age_select: slot age matrix plus oldest-ready one-hot grant.
//   CLK (falling-edge state), RESET (async active-low), FLUSH (clear)
//   alloc_fire/alloc_oh : slot being allocated this edge
//   valid               : current slot valid vector (pre-edge)
//   ready               : slots eligible for issue
//   grant               : one-hot oldest ready slot (zero if none)
// r_age[i][j] = 1 means slot j was allocated before slot i.
module age_select #(
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             alloc_fire,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0][DEPTH-1:0] r_age;

  // Age matrix: new slot is younger than every valid slot; its column is
  // cleared elsewhere so stale bits from a previous occupant disappear.
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_age <= '0;
    end else if (FLUSH) begin
      r_age <= '0;
    end else if (alloc_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) r_age[i] <= valid;
        else             r_age[i] <= r_age[i] & ~alloc_oh;
      end
    end
  end

  // Grant: ready with no older ready slot; unique because age is a total order.
  always_comb begin
    grant = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i] & ~|(r_age[i] & ready);
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: out-of-order issue queue with oldest-ready select.
//   CLK (state on falling edge), RESET (async active-low), FLUSH, STALL
//   busy/wakeup_valid/wakeup_reg : physical-register readiness tracking
//   bus (issue_scheduler_if.slave) : allocate port and registered issue port
//   occupancy : number of valid slots
// Option macro ISSUE_FAST_WAKEUP_EN: when defined, wakeup matches feed select
// in the same edge; otherwise select sees registered ready bits only.
module issue_scheduler
  import ooo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic                       STALL,
  input  logic [NUM_PREGS-1:0]       busy,
  input  logic                       wakeup_valid,
  input  logic [PREG_W-1:0]          wakeup_reg,
  issue_scheduler_if.slave           bus,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] r_valid, r_rdy_a, r_rdy_b;
  entry_t           r_entry [DEPTH];
  logic             r_issue_valid, r_halt;
  logic [ENTRY_W-1:0] r_issue_entry;
  logic [OCC_W-1:0] r_occ;

  entry_t             w_alloc;
  logic [DEPTH-1:0]   w_alloc_oh, w_wake_a, w_wake_b, w_ready, w_grant;
  logic               w_found, w_alloc_fire, w_issue_fire, w_out_free;
  logic [ENTRY_W-1:0] w_sel_entry;
  logic [OCC_W-1:0]   w_occ_next;

  assign w_alloc = entry_t'(bus.alloc_entry);

  // Free-slot search, wakeup compare, readiness and selected-entry mux.
  always_comb begin
    w_alloc_oh  = {DEPTH{1'b0}};
    w_found     = 1'b0;
    w_wake_a    = {DEPTH{1'b0}};
    w_wake_b    = {DEPTH{1'b0}};
    w_ready     = {DEPTH{1'b0}};
    w_sel_entry = {ENTRY_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && !w_found) begin
        w_alloc_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
      w_wake_a[i] = wakeup_valid & (r_entry[i].mapa == wakeup_reg);
      w_wake_b[i] = wakeup_valid & (r_entry[i].mapb == wakeup_reg);
`ifdef ISSUE_FAST_WAKEUP_EN
      w_ready[i]  = r_valid[i] & (r_rdy_a[i] | w_wake_a[i]) & (r_rdy_b[i] | w_wake_b[i]);
`else
      w_ready[i]  = r_valid[i] & r_rdy_a[i] & r_rdy_b[i];
`endif
      if (w_grant[i]) w_sel_entry = w_sel_entry | r_entry[i];
    end
  end

  age_select #(.DEPTH(DEPTH)) u_age_select (
    .CLK        (CLK),
    .RESET      (RESET),
    .FLUSH      (FLUSH),
    .alloc_fire (w_alloc_fire),
    .alloc_oh   (w_alloc_oh),
    .valid      (r_valid),
    .ready      (w_ready),
    .grant      (w_grant)
  );

  assign w_out_free   = !r_issue_valid | bus.exe_ready;
  assign w_issue_fire = w_out_free & (|w_grant) & !STALL & !FLUSH;
  assign w_alloc_fire = bus.alloc_valid & !r_halt & w_found & !STALL & !FLUSH;
  assign w_occ_next   = r_occ + OCC_W'(w_alloc_fire) - OCC_W'(w_issue_fire);

  // Slot state: wakeups apply even under STALL; an issued slot frees this
  // edge but the free search above only saw the pre-edge valid vector.
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= {DEPTH{1'b0}};
      r_rdy_a <= {DEPTH{1'b0}};
      r_rdy_b <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= entry_t'({ENTRY_W{1'b0}});
    end else if (FLUSH) begin
      r_valid <= {DEPTH{1'b0}};
      r_rdy_a <= {DEPTH{1'b0}};
      r_rdy_b <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && w_wake_a[i]) r_rdy_a[i] <= 1'b1;
        if (r_valid[i] && w_wake_b[i]) r_rdy_b[i] <= 1'b1;
        if (w_issue_fire && w_grant[i]) r_valid[i] <= 1'b0;
        if (w_alloc_fire && w_alloc_oh[i]) begin
          r_valid[i] <= 1'b1;
          r_entry[i] <= w_alloc;
          r_rdy_a[i] <= src_ready(w_alloc.mapa, busy, wakeup_valid, wakeup_reg);
          r_rdy_b[i] <= src_ready(w_alloc.mapb, busy, wakeup_valid, wakeup_reg);
        end
      end
    end
  end

  // Issue register, occupancy and halt. Output holds under STALL or when
  // execute has not taken the current entry.
  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_issue_valid <= 1'b0;
      r_issue_entry <= {ENTRY_W{1'b0}};
      r_occ         <= {OCC_W{1'b0}};
      r_halt        <= 1'b0;
    end else if (FLUSH) begin
      r_issue_valid <= 1'b0;
      r_issue_entry <= {ENTRY_W{1'b0}};
      r_occ         <= {OCC_W{1'b0}};
      r_halt        <= 1'b0;
    end else begin
      r_occ  <= w_occ_next;
      r_halt <= (w_occ_next == OCC_W'(DEPTH));
      if (!STALL && w_out_free) begin
        r_issue_valid <= |w_grant;
        if (|w_grant) r_issue_entry <= w_sel_entry;
      end
    end
  end

  assign bus.issue_valid = r_issue_valid;
  assign bus.issue_entry = r_issue_entry;
  assign bus.issue_halt  = r_halt;
  assign occupancy       = r_occ;

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
  import ooo_pkg::*;

`ifdef ISSUE_FAST_WAKEUP_EN
  localparam int FW = 1;
`else
  localparam int FW = 0;
`endif

  logic                 CLK = 1'b0;
  logic                 RESET, FLUSH, STALL, wakeup_valid;
  logic [NUM_PREGS-1:0] busy;
  logic [PREG_W-1:0]    wakeup_reg;
  logic [4:0]           occupancy;

  issue_scheduler_if bus ();

  issue_scheduler #(.DEPTH(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .FLUSH        (FLUSH),
    .STALL        (STALL),
    .busy         (busy),
    .wakeup_valid (wakeup_valid),
    .wakeup_reg   (wakeup_reg),
    .bus          (bus.slave),
    .occupancy    (occupancy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic               av;
    logic [ENTRY_W-1:0] ae;
    logic [63:0]        bz;
    logic               wv;
    logic [5:0]         wr;
    logic               ex;
    logic               st;
    logic               fl;
    logic               x_iv;
    logic [ENTRY_W-1:0] x_ie;
    logic               x_halt;
    logic [4:0]         x_occ;
  } vec_t;

  vec_t tbl [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [ENTRY_W-1:0] mk(input int a, input int b, input int t);
    entry_t e;
    e.control = 88'(t);
    e.instr   = 32'hA000_0000 + 32'(t);
    e.pc      = 32'h0000_1000 + 32'(t) * 32'd4;
    e.mapc    = 6'd0;
    e.mapb    = 6'(b);
    e.mapa    = 6'(a);
    return e;
  endfunction

  function automatic vec_t v(input logic av, input logic [ENTRY_W-1:0] ae,
                             input logic [63:0] bz, input logic wv, input logic [5:0] wr,
                             input logic ex, input logic st, input logic fl,
                             input logic x_iv, input logic [ENTRY_W-1:0] x_ie,
                             input logic x_halt, input logic [4:0] x_occ);
    vec_t r;
    r.av = av; r.ae = ae; r.bz = bz; r.wv = wv; r.wr = wr; r.ex = ex;
    r.st = st; r.fl = fl; r.x_iv = x_iv; r.x_ie = x_ie; r.x_halt = x_halt; r.x_occ = x_occ;
    return r;
  endfunction

  task automatic check_out(input string nm, input logic xiv, input logic [ENTRY_W-1:0] xie,
                           input logic xh, input logic [4:0] xo);
    checks++;
    if (bus.issue_valid !== xiv) begin
      errors++;
      $display("FAIL %s issue_valid got %b exp %b", nm, bus.issue_valid, xiv);
    end
    checks++;
    if (bus.issue_entry !== xie) begin
      errors++;
      $display("FAIL %s issue_entry got %h exp %h", nm, bus.issue_entry, xie);
    end
    checks++;
    if (bus.issue_halt !== xh) begin
      errors++;
      $display("FAIL %s issue_halt got %b exp %b", nm, bus.issue_halt, xh);
    end
    checks++;
    if (occupancy !== xo) begin
      errors++;
      $display("FAIL %s occupancy got %0d exp %0d", nm, occupancy, xo);
    end
  endtask

  // Drive one edge worth of inputs, then sample just after the falling edge.
  task automatic apply(input string nm, input vec_t x);
    bus.alloc_valid = x.av;
    bus.alloc_entry = x.ae;
    busy            = x.bz;
    wakeup_valid    = x.wv;
    wakeup_reg      = x.wr;
    bus.exe_ready   = x.ex;
    STALL           = x.st;
    FLUSH           = x.fl;
    @(negedge CLK);
    #1;
    check_out(nm, x.x_iv, x.x_ie, x.x_halt, x.x_occ);
  endtask

  initial begin
    logic [ENTRY_W-1:0] z, e1, e2, e3, e4, e5, e6, e7, e8;
    logic [63:0] b5, b7, b9;
    z  = {ENTRY_W{1'b0}};
    e1 = mk(3, 4, 1);  e2 = mk(5, 1, 2);  e3 = mk(2, 3, 3);  e4 = mk(1, 2, 4);
    e5 = mk(1, 2, 5);  e6 = mk(3, 3, 6);  e7 = mk(0, 9, 7);  e8 = mk(1, 1, 8);
    b5 = 64'd1 << 5;   b7 = 64'd1 << 7;   b9 = 64'd1 << 9;

    // basic allocate -> issue -> drain
    tbl.push_back(v(1'b1, e1, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, z,  1'b0, 5'd1));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, e1, 1'b0, 5'd0));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e1, 1'b0, 5'd0));
    // A waits on reg 5, younger B issues first, wakeup releases A
    tbl.push_back(v(1'b1, e2, b5,    1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e1, 1'b0, 5'd1));
    tbl.push_back(v(1'b1, e3, b5,    1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e1, 1'b0, 5'd2));
    tbl.push_back(v(1'b0, z,  b5,    1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, e3, 1'b0, 5'd1));
    if (FW == 1) begin
      tbl.push_back(v(1'b0, z, b5,    1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, e2, 1'b0, 5'd0));
      tbl.push_back(v(1'b0, z, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e2, 1'b0, 5'd0));
    end else begin
      tbl.push_back(v(1'b0, z, b5,    1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, e3, 1'b0, 5'd1));
      tbl.push_back(v(1'b0, z, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, e2, 1'b0, 5'd0));
    end
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e2, 1'b0, 5'd0));
    // three ready entries behind a busy execute port; E6 reuses slot 0
    tbl.push_back(v(1'b1, e4, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, e2, 1'b0, 5'd1));
    tbl.push_back(v(1'b1, e5, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, e4, 1'b0, 5'd1));
    tbl.push_back(v(1'b1, e6, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, e4, 1'b0, 5'd2));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(1'b0, z, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, e4, 1'b0, 5'd2));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, e5, 1'b0, 5'd1));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, e6, 1'b0, 5'd0));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e6, 1'b0, 5'd0));
    // allocate-time wakeup bypass on MAPB=9
    tbl.push_back(v(1'b1, e7, b9,    1'b1, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0, e6, 1'b0, 5'd1));
    tbl.push_back(v(1'b0, z,  b9,    1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, e7, 1'b0, 5'd0));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e7, 1'b0, 5'd0));
    // STALL drops allocation and freezes issue
    tbl.push_back(v(1'b1, e8, 64'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, e7, 1'b0, 5'd0));
    tbl.push_back(v(1'b1, e8, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e7, 1'b0, 5'd1));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, e7, 1'b0, 5'd1));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, e8, 1'b0, 5'd0));
    tbl.push_back(v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e8, 1'b0, 5'd0));

    // reset, released away from the falling edge
    RESET = 1'b0; FLUSH = 1'b0; STALL = 1'b0; busy = 64'd0;
    wakeup_valid = 1'b0; wakeup_reg = 6'd0;
    bus.alloc_valid = 1'b0; bus.alloc_entry = z; bus.exe_ready = 1'b0;
    #12;
    check_out("reset", 1'b0, z, 1'b0, 5'd0);
    #1 RESET = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // fill all 16 slots waiting on reg 7
    for (int i = 0; i < 16; i++)
      apply($sformatf("fill%0d", i),
            v(1'b1, mk(7, 0, 32 + i), b7, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0,
              1'b0, e8, (i == 15), 5'(i + 1)));
    apply("full_drop", v(1'b1, mk(7, 0, 99), b7, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, e8, 1'b1, 5'd16));
    if (FW == 1)
      apply("wake7", v(1'b0, z, b7, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, mk(7, 0, 32), 1'b0, 5'd15));
    else
      apply("wake7", v(1'b0, z, b7, 1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, e8, 1'b1, 5'd16));
    for (int k = 0; k < 2; k++)
      apply($sformatf("drain%0d", k),
            v(1'b0, z, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0,
              1'b1, mk(7, 0, 32 + k + FW), 1'b0, 5'(15 - k - FW)));
    apply("hold_full", v(1'b0, z, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,
                         1'b1, mk(7, 0, 33 + FW), 1'b0, 5'(14 - FW)));
    apply("flush",      v(1'b0, z, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, z, 1'b0, 5'd0));
    apply("post_flush", v(1'b0, z, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, z, 1'b0, 5'd0));

    // asynchronous reset while an entry is being presented
    apply("pre_rst_a", v(1'b1, e1, 64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, z,  1'b0, 5'd1));
    apply("pre_rst_b", v(1'b0, z,  64'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, e1, 1'b0, 5'd0));
    #3 RESET = 1'b0;
    #1 check_out("async_rst", 1'b0, z, 1'b0, 5'd0);
    #1 RESET = 1'b1;
    apply("post_rst", v(1'b0, z, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, z, 1'b0, 5'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
